// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Requester indices; a lower index means a higher priority.
  localparam logic [1:0] REQ_ERR   = 2'd0;
  localparam logic [1:0] REQ_CHG   = 2'd1;
  localparam logic [1:0] REQ_PRICE = 2'd2;

  // Code the digit driver renders as a dark digit.
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  function automatic logic [3:0] sanitize_nibble(input logic [3:0] n);
    return (n > 4'd9) ? BLANK_DIGIT : n;
  endfunction

  function automatic logic [15:0] sanitize_word(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = sanitize_nibble(w[i*4 +: 4]);
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Loadable down-counter that parks at zero; used for message hold and gap timing.
module disp_hold_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  // Load takes precedence; otherwise count down and stop at zero (never wraps).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/seg_disp_scheduler.sv
// Arbitrates display messages: fixed-priority grant, timed hold, blank gap, idle fallback.
module seg_disp_scheduler
  import seg_disp_pkg::*;
#(
  parameter int         HOLD_CYC = 100_000_000,
  parameter int         GAP_CYC  = 5_000_000,
  parameter logic [3:0] DP_MASK  = 4'b0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  req,
  input  logic [47:0] req_bcd,
  input  logic [15:0] idle_bcd,
  output logic [2:0]  ack,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic [15:0] disp_bcd,
  output logic [3:0]  disp_dp,
  output logic        disp_blank
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] GAP_LOAD  = (GAP_CYC > 0) ? TW'(GAP_CYC - 1) : '0;

  state_t          state, state_n;
  logic [2:0]      avail;
  logic            any_req;
  logic [1:0]      win_id;
  logic [15:0]     win_word;
  logic            hi_pri;
  logic            grant, finish;
  logic            tmr_load, tmr_zero;
  logic [TW-1:0]   tmr_val, tmr_value;
  logic [2:0]      ack_n;
  logic            busy_n, blank_n;
  logic [1:0]      id_n;
  logic [15:0]     bcd_n;

  disp_hold_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // The requester just acknowledged still holds req for one cycle, so mask it out.
  assign avail   = req & ~ack;
  assign any_req = |avail;
  assign hi_pri  = any_req && (win_id < active_id);

  // Fixed-priority winner (lowest set index) and its BCD word.
  always_comb begin
    win_id = REQ_ERR;
    if (avail[REQ_PRICE]) win_id = REQ_PRICE;
    if (avail[REQ_CHG])   win_id = REQ_CHG;
    if (avail[REQ_ERR])   win_id = REQ_ERR;
    case (win_id)
      REQ_CHG:   win_word = req_bcd[31:16];
      REQ_PRICE: win_word = req_bcd[47:32];
      default:   win_word = req_bcd[15:0];
    endcase
  end

  // Next-state and next-output decode; preemption is evaluated before hold expiry.
  always_comb begin
    state_n  = state;
    ack_n    = '0;
    busy_n   = busy;
    id_n     = active_id;
    bcd_n    = disp_bcd;
    blank_n  = disp_blank;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LOAD;
    grant    = 1'b0;
    finish   = 1'b0;

    case (state)
      ST_IDLE: begin
        busy_n  = 1'b0;
        id_n    = '0;
        blank_n = 1'b0;
        bcd_n   = sanitize_word(idle_bcd);
        grant   = any_req;
      end
      ST_SHOW: begin
        if (hi_pri) begin
          grant = 1'b1;
        end else if (tmr_zero) begin
          if (GAP_CYC > 0) begin
            state_n  = ST_GAP;
            blank_n  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_GAP: begin
        blank_n = 1'b1;
        finish  = tmr_zero;
      end
      default: state_n = ST_IDLE;
    endcase

    if (finish) begin
      if (any_req) begin
        grant = 1'b1;
      end else begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        id_n    = '0;
        blank_n = 1'b0;
        bcd_n   = sanitize_word(idle_bcd);
      end
    end

    if (grant) begin
      state_n  = ST_SHOW;
      ack_n    = 3'b001 << win_id;
      id_n     = win_id;
      bcd_n    = sanitize_word(win_word);
      blank_n  = 1'b0;
      busy_n   = 1'b1;
      tmr_load = 1'b1;
      tmr_val  = HOLD_LOAD;
    end
  end

  // State and registered outputs; reset aborts any message in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      ack        <= '0;
      busy       <= 1'b0;
      active_id  <= '0;
      disp_bcd   <= '0;
      disp_dp    <= '0;
      disp_blank <= 1'b1;
    end else begin
      state      <= state_n;
      ack        <= ack_n;
      busy       <= busy_n;
      active_id  <= id_n;
      disp_bcd   <= bcd_n;
      disp_dp    <= blank_n ? 4'h0 : DP_MASK;
      disp_blank <= blank_n;
    end
  end

endmodule

// File: tb/tb_seg_disp_scheduler.sv
// Bench for seg_disp_scheduler: HOLD_CYC=8 / GAP_CYC=2 instance plus a GAP_CYC=0 instance.
module tb_seg_disp_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  req, req_z;
  logic [47:0] rbcd, rbcd_z;
  logic [15:0] idle_bcd;

  logic [2:0]  ack, ack_z;
  logic        busy, busy_z;
  logic [1:0]  id, id_z;
  logic [15:0] bcd, bcd_z;
  logic [3:0]  dp, dp_z;
  logic        blank, blank_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  seg_disp_scheduler #(.HOLD_CYC(8), .GAP_CYC(2), .DP_MASK(4'b0100)) u_dut (
    .CLK(CLK), .RST(RST), .req(req), .req_bcd(rbcd), .idle_bcd(idle_bcd),
    .ack(ack), .busy(busy), .active_id(id), .disp_bcd(bcd), .disp_dp(dp),
    .disp_blank(blank)
  );

  seg_disp_scheduler #(.HOLD_CYC(8), .GAP_CYC(0), .DP_MASK(4'b0100)) u_dut_ng (
    .CLK(CLK), .RST(RST), .req(req_z), .req_bcd(rbcd_z), .idle_bcd(idle_bcd),
    .ack(ack_z), .busy(busy_z), .active_id(id_z), .disp_bcd(bcd_z), .disp_dp(dp_z),
    .disp_blank(blank_z)
  );

  typedef struct {
    string       tag;
    bit          z;      // 1: drive/check the GAP_CYC=0 instance
    logic [2:0]  req;
    logic [47:0] rbcd;
    logic [2:0]  ack;
    logic        busy;
    logic [1:0]  id;
    logic [15:0] bcd;
    bit          care;   // disp_bcd is checked only when set
    logic        blank;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string tag, bit z, logic [2:0] r,
                              logic [15:0] b0, logic [15:0] b1, logic [15:0] b2,
                              logic [2:0] a, logic bz, logic [1:0] i,
                              logic [15:0] d, bit care, logic bl);
    vec_t v;
    v.tag = tag; v.z = z; v.req = r; v.rbcd = {b2, b1, b0};
    v.ack = a; v.busy = bz; v.id = i; v.bcd = d; v.care = care; v.blank = bl;
    return v;
  endfunction

  task automatic add(string tag, int n, bit z, logic [2:0] r,
                     logic [15:0] b0, logic [15:0] b1, logic [15:0] b2,
                     logic [2:0] a, logic bz, logic [1:0] i,
                     logic [15:0] d, bit care, logic bl);
    for (int k = 0; k < n; k++) tbl.push_back(mk(tag, z, r, b0, b1, b2, a, bz, i, d, care, bl));
  endtask

  task automatic check_head();
    vec_t v;
    logic [2:0] a; logic b; logic [1:0] i; logic [15:0] d; logic [3:0] p; logic bl;
    logic [3:0] exp_dp;
    bit ok;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    v = sb.pop_front();
    if (v.z) {a, b, i, d, p, bl} = {ack_z, busy_z, id_z, bcd_z, dp_z, blank_z};
    else     {a, b, i, d, p, bl} = {ack, busy, id, bcd, dp, blank};
    exp_dp = v.blank ? 4'h0 : 4'b0100;
    ok = (a === v.ack) && (b === v.busy) && (i === v.id) && (bl === v.blank) &&
         (p === exp_dp) && (!v.care || (d === v.bcd));
    if (!ok) begin
      n_fail++;
      $display("FAIL %s @%0t: got ack=%b busy=%b id=%0d bcd=%h blank=%b dp=%b; want ack=%b busy=%b id=%0d bcd=%h(care=%0d) blank=%b dp=%b",
               v.tag, $time, a, b, i, d, bl, p, v.ack, v.busy, v.id, v.bcd, v.care, v.blank, exp_dp);
    end
  endtask

  // Drive one row's inputs, push its expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    if (v.z) begin
      req_z = v.req; rbcd_z = v.rbcd; req = 3'b000;
    end else begin
      req = v.req; rbcd = v.rbcd; req_z = 3'b000;
    end
    sb.push_back(v);
    @(posedge CLK);
    #1;
    check_head();
  endtask

  task automatic check_now(input vec_t v);
    sb.push_back(v);
    check_head();
  endtask

  initial begin
    RST = 1'b1; req = '0; req_z = '0; rbcd = '0; rbcd_z = '0; idle_bcd = 16'h0075;
    repeat (2) @(posedge CLK);
    #1;
    check_now(mk("reset", 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 16'h0000, 1, 1));
    check_now(mk("reset_ng", 1, 3'b000, 0, 0, 0, 3'b000, 0, 0, 16'h0000, 1, 1));
    RST = 1'b0;

    // after release: idle value shown, not blank
    add("idle_after_rst", 1, 0, 3'b000, 0, 0, 0,          3'b000, 0, 0, 16'h0075, 1, 0);
    // single price request
    add("single_ack",     1, 0, 3'b100, 0, 0, 16'h0050,   3'b100, 1, 2, 16'h0050, 1, 0);
    add("single_show",    7, 0, 3'b000, 0, 0, 16'h0050,   3'b000, 1, 2, 16'h0050, 1, 0);
    add("single_gap",     2, 0, 3'b000, 0, 0, 16'h0050,   3'b000, 1, 2, 16'h0000, 0, 1);
    add("single_idle",    1, 0, 3'b000, 0, 0, 16'h0050,   3'b000, 0, 0, 16'h0075, 1, 0);
    // contention: error wins, price follows straight out of the gap
    add("cont_ack0",      1, 0, 3'b101, 16'h0012, 0, 16'h0050, 3'b001, 1, 0, 16'h0012, 1, 0);
    add("cont_show0",     7, 0, 3'b100, 16'h0012, 0, 16'h0050, 3'b000, 1, 0, 16'h0012, 1, 0);
    add("cont_gap",       2, 0, 3'b100, 16'h0012, 0, 16'h0050, 3'b000, 1, 0, 16'h0000, 0, 1);
    add("cont_ack2",      1, 0, 3'b100, 16'h0012, 0, 16'h0050, 3'b100, 1, 2, 16'h0050, 1, 0);
    add("cont_show2",     7, 0, 3'b000, 16'h0012, 0, 16'h0050, 3'b000, 1, 2, 16'h0050, 1, 0);
    add("cont_gap2",      2, 0, 3'b000, 16'h0012, 0, 16'h0050, 3'b000, 1, 2, 16'h0000, 0, 1);
    add("cont_idle",      1, 0, 3'b000, 16'h0012, 0, 16'h0050, 3'b000, 0, 0, 16'h0075, 1, 0);
    // preemption at timer=3, then a change request waits behind the error message
    add("pre_ack2",       1, 0, 3'b100, 0, 0, 16'h0050,        3'b100, 1, 2, 16'h0050, 1, 0);
    add("pre_show2",      4, 0, 3'b000, 0, 0, 16'h0050,        3'b000, 1, 2, 16'h0050, 1, 0);
    add("pre_ack0",       1, 0, 3'b001, 16'h0099, 0, 16'h0050, 3'b001, 1, 0, 16'h0099, 1, 0);
    add("pre_show0",      7, 0, 3'b010, 16'h0099, 16'h0033, 0, 3'b000, 1, 0, 16'h0099, 1, 0);
    add("pre_gap",        2, 0, 3'b010, 16'h0099, 16'h0033, 0, 3'b000, 1, 0, 16'h0000, 0, 1);
    add("pre_ack1",       1, 0, 3'b010, 16'h0099, 16'h0033, 0, 3'b010, 1, 1, 16'h0033, 1, 0);
    add("pre_show1",      7, 0, 3'b000, 16'h0099, 16'h0033, 0, 3'b000, 1, 1, 16'h0033, 1, 0);
    add("pre_gap1",       2, 0, 3'b000, 16'h0099, 16'h0033, 0, 3'b000, 1, 1, 16'h0000, 0, 1);
    add("pre_idle",       1, 0, 3'b000, 16'h0099, 16'h0033, 0, 3'b000, 0, 0, 16'h0075, 1, 0);
    // expiry and higher-priority request on the same edge: preemption, no gap
    add("exp_ack2",       1, 0, 3'b100, 0, 0, 16'h0050,        3'b100, 1, 2, 16'h0050, 1, 0);
    add("exp_show2",      7, 0, 3'b000, 0, 0, 16'h0050,        3'b000, 1, 2, 16'h0050, 1, 0);
    add("exp_ack0",       1, 0, 3'b001, 16'h0099, 0, 16'h0050, 3'b001, 1, 0, 16'h0099, 1, 0);
    add("exp_show0",      7, 0, 3'b000, 16'h0099, 0, 16'h0050, 3'b000, 1, 0, 16'h0099, 1, 0);
    add("exp_gap",        2, 0, 3'b000, 16'h0099, 0, 16'h0050, 3'b000, 1, 0, 16'h0000, 0, 1);
    add("exp_idle",       1, 0, 3'b000, 16'h0099, 0, 16'h0050, 3'b000, 0, 0, 16'h0075, 1, 0);
    // sanitising and value latched at grant
    add("san_ack",        1, 0, 3'b010, 0, 16'h00A5, 0,        3'b010, 1, 1, 16'h00F5, 1, 0);
    add("san_hold",       7, 0, 3'b000, 0, 16'h1234, 0,        3'b000, 1, 1, 16'h00F5, 1, 0);
    add("san_gap",        2, 0, 3'b000, 0, 16'h1234, 0,        3'b000, 1, 1, 16'h0000, 0, 1);
    add("san_idle",       1, 0, 3'b000, 0, 16'h1234, 0,        3'b000, 0, 0, 16'h0075, 1, 0);
    // GAP_CYC=0 instance: switch on the expiry edge, never blank
    add("ng_ack0",        1, 1, 3'b101, 16'h0012, 0, 16'h0050, 3'b001, 1, 0, 16'h0012, 1, 0);
    add("ng_show0",       7, 1, 3'b100, 16'h0012, 0, 16'h0050, 3'b000, 1, 0, 16'h0012, 1, 0);
    add("ng_ack2",        1, 1, 3'b100, 16'h0012, 0, 16'h0050, 3'b100, 1, 2, 16'h0050, 1, 0);
    add("ng_show2",       7, 1, 3'b000, 16'h0012, 0, 16'h0050, 3'b000, 1, 2, 16'h0050, 1, 0);
    add("ng_idle",        2, 1, 3'b000, 16'h0012, 0, 16'h0050, 3'b000, 0, 0, 16'h0075, 1, 0);

    foreach (tbl[k]) apply(tbl[k]);

    // Reset asserted mid-SHOW: outputs return to reset values and the message is dropped.
    apply(mk("rst_ack",  0, 3'b100, 0, 0, 16'h0050, 3'b100, 1, 2, 16'h0050, 1, 0));
    apply(mk("rst_show", 0, 3'b000, 0, 0, 16'h0050, 3'b000, 1, 2, 16'h0050, 1, 0));
    apply(mk("rst_show", 0, 3'b000, 0, 0, 16'h0050, 3'b000, 1, 2, 16'h0050, 1, 0));
    #2 RST = 1'b1;
    #1;
    check_now(mk("rst_async", 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 16'h0000, 1, 1));
    apply(mk("rst_held", 0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 16'h0000, 1, 1));
    RST = 1'b0;
    for (int k = 0; k < 12; k++)
      apply(mk("rst_no_resume", 0, 3'b000, 0, 0, 16'h0050, 3'b000, 0, 0, 16'h0075, 1, 0));

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
